// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the TinyMIPS EX stage.
// Executes MULT, MULTU, DIV and DIVU one result bit per cycle. While an
// operation is in flight it freezes the front of the pipeline through
// stall_req. It then presents a registered HI/LO pair for a single cycle,
// which is when done is high.

module muldiv_unit #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;

  // Latched operation flavour and result signs
  logic          isDiv_q;
  logic          negRes_q;
  logic          negRem_q;

  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [63:0]   acc_q;
  logic [63:0]   mcand_q;
  logic [31:0]   mplier_q;

  // Divide datapath: partial remainder, dividend/quotient shift register, divisor
  logic [31:0]   rem_q;
  logic [31:0]   quot_q;
  logic [31:0]   divisor_q;

  // Architectural result registers
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  // Operand decode at issue time
  logic          isDivOp;
  logic          isSignedOp;
  logic          divByZero;
  logic [31:0]   magA;
  logic [31:0]   magB;

  // Per-iteration next values and sign-corrected final values
  logic [63:0]   accNext;
  logic [32:0]   remShift;
  logic [32:0]   remDiff;
  logic [31:0]   remNext;
  logic [31:0]   quotNext;
  logic [63:0]   prodFinal;
  logic [31:0]   quotFinal;
  logic [31:0]   remFinal;

  // Decode the incoming instruction: signed ops work on magnitudes, and a
  // zero divisor short-circuits straight to the fixed divide-by-zero result.
  always_comb begin
    isDivOp    = op[1];
    isSignedOp = ~op[0];
    magA       = (isSignedOp && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
    magB       = (isSignedOp && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2;
    divByZero  = isDivOp && (operand_2 == 32'd0);
  end

  // One iteration of shift-add multiply and restoring divide. The 33-bit
  // trial difference goes negative exactly when the divisor does not fit,
  // so its top bit serves as the borrow and selects restore vs. keep.
  always_comb begin
    accNext  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    remShift = {rem_q, quot_q[31]};
    remDiff  = remShift - {1'b0, divisor_q};
    if (remDiff[32]) begin
      remNext  = remShift[31:0];
      quotNext = {quot_q[30:0], 1'b0};
    end else begin
      remNext  = remDiff[31:0];
      quotNext = {quot_q[30:0], 1'b1};
    end
    prodFinal = negRes_q ? (~accNext + 64'd1) : accNext;
    quotFinal = negRes_q ? (~quotNext + 32'd1) : quotNext;
    remFinal  = negRem_q ? (~remNext + 32'd1) : remNext;
  end

  // Control FSM and datapath registers. Reset beats flush beats start.
  // Flush abandons the operation but keeps the last completed HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      divisor_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            isDiv_q   <= isDivOp;
            negRes_q  <= isSignedOp & (operand_1[31] ^ operand_2[31]);
            negRem_q  <= isSignedOp & operand_1[31];
            count_q   <= '0;
            acc_q     <= 64'd0;
            mcand_q   <= {32'd0, magA};
            mplier_q  <= magB;
            rem_q     <= 32'd0;
            quot_q    <= magA;
            divisor_q <= magB;
            if (divByZero) begin
              hi_q    <= operand_1;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q    <= accNext;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          rem_q    <= remNext;
          quot_q   <= quotNext;
          count_q  <= count_q + CW'(1);
          if (count_q == LAST) begin
            if (isDiv_q) begin
              hi_q <= remFinal;
              lo_q <= quotFinal;
            end else begin
              hi_q <= prodFinal[63:32];
              lo_q <= prodFinal[31:0];
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline from the issue cycle through the last iteration; the
  // DONE cycle is not stalled so EX can consume the result.
  assign stall_req = ((state_q == IDLE) && start && !flush) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
